clock_divider_prog: RTL
=======================

# clock_divider_prog

Runtime-programmable clock divider producing a nominally 50%-duty square wave plus a one-cycle period tick from the single system clock. It replaces fixed-divisor dividers wherever a design needs a rate chosen or changed while running, e.g. stopwatch speed modes or simulation-fast rates. Divisor changes are double-buffered and take effect only at a period boundary, so the output never glitches. Outputs are intended as enables and timing references, not as clocks for other logic.

## Interface
- `WIDTH`, 28: width of counter and divisor.
- `DEFAULT_DIV`, 50000000: divisor loaded at reset (1 Hz from 50 MHz). Must satisfy 2 <= `DEFAULT_DIV` <= 2^`WIDTH`-1.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  when 0, the counter and both wave outputs freeze. Divisor loads are still accepted while disabled.
- `div_load`  in  1  one-cycle strobe; samples `div_value`.
- `div_value`  in  WIDTH  requested divisor D. Legal range is D >= 2.
- `new_clock`  out  1  divided square wave.
- `tick`  out  1  one-cycle pulse at the start of each output period.
- `div_err`  out  1  one-cycle pulse when a load is rejected.
- `div_active`  out  WIDTH  divisor currently in effect.

## Operation
- State registers:
  - `counter` (WIDTH bits)
  - `active_div`
  - `pending_div`
  - `pending_valid`
  - registered outputs
- Reset (sync, highest priority) sets:
  - `counter`=0
  - `active_div`=`DEFAULT_DIV`
  - `pending_valid`=0
  - `new_clock`=0
  - `tick`=0
  - `div_err`=0
- Counting, on each edge with `enable`=1:
  - if `counter` >= `active_div`-1, then `counter`<=0 (wrap)
  - otherwise `counter`<=`counter`+1
- Wave, on each enabled edge:
  - `new_clock`<=(`counter` < `active_div`/2), using integer division
  - even D gives D/2 cycles high and D/2 low
  - odd D gives floor(D/2) high and ceil(D/2) low
- Tick, on each enabled edge: `tick`<=(`counter`==0). `tick` is forced to 0 while `enable`=0.
- Load handling:
  - `div_load`=1 with `div_value`>=2: `pending_div`<=`div_value` and `pending_valid`<=1.
  - `div_load`=1 with `div_value`<2: the value is rejected and `div_err`<=1 for one cycle. Pending state is unchanged.
  - `div_err` is 0 on all other cycles.
- Apply at wrap: on an enabled wrap edge with `pending_valid`=1, `active_div`<=`pending_div` and `pending_valid`<=0. The new divisor governs the period starting at `counter`=0.
- Load coinciding with wrap: a valid load on the same edge as a wrap applies `div_value` directly at that wrap, with `pending_valid` left 0. A pending value is then superseded.
- Multiple loads before a wrap: the last valid one wins.
- `div_active` = `active_div`, combinational from the register.

## Timing
- Output latency: `new_clock` and `tick` are registered from `counter`, so they lag the counter by one cycle.
- After `reset` deasserts with `enable`=1:
  - first edge: `tick`=1 and `new_clock`=1
  - `tick` then repeats every `active_div` cycles
- Divisor change latency: takes effect at the first wrap after the load. Worst case is `active_div` cycles; the period in progress always completes at the old divisor.
- Freeze and resume: dropping `enable` holds `counter`, `new_clock` and `active_div` exactly. On resume, counting continues with no lost or extra cycles.
- Reset mid-period aborts immediately:
  - the pending load is discarded
  - `active_div` returns to `DEFAULT_DIV`
- No combinational path from inputs to outputs, except `div_active` from its register.

## Test plan
- Reset behaviour, with `DEFAULT_DIV`=4 and `enable`=1: release reset, then require
  - `new_clock` pattern 1,1,0,0 repeating
  - `tick` high on cycles 1,5,9
  - `div_active`=4
- Runtime load: load `div_value`=6 when `counter`=1 → current period finishes at 4 cycles, then 3 high/3 low. `div_active` changes to 6 exactly at the wrap edge.
- Odd divisor and wrap collision:
  - load 5 on the wrap edge → next period applies 5 immediately, 2 high/3 low
  - load 7 then 9 within one period → 9 applies
- Rejected loads: load 1, then load 0 → `div_err` pulses one cycle each. `div_active` unchanged and the wave is undisturbed.
- Freeze: deassert `enable` for 10 cycles mid-high-phase → outputs hold, `tick`=0, and the phase resumes exactly where it stopped.
- Reset mid-operation: reset asserted with a pending load of 8 → after release, `div_active`=`DEFAULT_DIV`, and 8 is never applied.

Source files
------------

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider with a square-wave output,
// a period tick, and divisor changes deferred to period boundaries.
module clock_divider_prog #(
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             new_clock,
  output logic             tick,
  output logic             div_err,
  output logic [WIDTH-1:0] div_active
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] active_div;
  logic [WIDTH-1:0] pending_div;
  logic             pending_valid;
  logic             wrap;
  logic             load_ok;
  logic             load_bad;

  // End-of-period detection and load qualification.
  always_comb begin
    wrap     = (counter >= active_div - ONE);
    load_ok  = div_load && (div_value >= TWO);
    load_bad = div_load && (div_value < TWO);
  end

  // Counter, wave, tick, and double-buffered divisor update.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter       <= '0;
      active_div    <= DEF;
      pending_div   <= DEF;
      pending_valid <= 1'b0;
      new_clock     <= 1'b0;
      tick          <= 1'b0;
      div_err       <= 1'b0;
    end else begin
      div_err <= load_bad;
      if (enable) begin
        new_clock <= (counter < (active_div >> 1));
        tick      <= (counter == '0);
        if (wrap) begin
          counter       <= '0;
          pending_valid <= 1'b0;
          if (load_ok) begin
            active_div <= div_value;
          end else if (pending_valid) begin
            active_div <= pending_div;
          end
        end else begin
          counter <= counter + ONE;
          if (load_ok) begin
            pending_div   <= div_value;
            pending_valid <= 1'b1;
          end
        end
      end else begin
        tick <= 1'b0;
        if (load_ok) begin
          pending_div   <= div_value;
          pending_valid <= 1'b1;
        end
      end
    end
  end

  assign div_active = active_div;

endmodule
